// File: rtl/pwm_reg_fifo_mc.sv
// Multi-channel PWM register front end: per-channel duty FIFOs plus one period FIFO,
// committed to active registers on period start, with sticky overflow/underflow status.
module pwm_reg_fifo_mc #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned AW       = $clog2(CHANNELS + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_wr_en,
    input  logic [AW-1:0]             i_wr_addr,
    input  logic [WIDTH-1:0]          i_wr_data,
    input  logic                      i_period_start,
    input  logic                      i_sync_mode,
    input  logic                      i_flag_clr,
    output logic [CHANNELS*WIDTH-1:0] o_duty,
    output logic [WIDTH-1:0]          o_period,
    output logic [CHANNELS:0]         o_full,
    output logic [CHANNELS:0]         o_empty,
    output logic [CHANNELS:0]         o_overflow,
    output logic [CHANNELS:0]         o_underflow,
    output logic                      o_update
);
    localparam int unsigned NF = CHANNELS + 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [NF][DEPTH];
    logic [PW-1:0]    wptr_q [NF];
    logic [PW-1:0]    wptr_d [NF];
    logic [PW-1:0]    rptr_q [NF];
    logic [PW-1:0]    rptr_d [NF];
    logic [CW-1:0]    cnt_q  [NF];
    logic [CW-1:0]    cnt_d  [NF];
    logic [WIDTH-1:0] act_q  [NF];
    logic [WIDTH-1:0] act_d  [NF];
    logic [NF-1:0]    ovf_q, ovf_d;
    logic [NF-1:0]    udf_q, udf_d;
    logic             update_q, update_d;

    logic [NF-1:0]    empty, full, push, pop, push_ok;
    logic             all_ne;

    always_comb begin
        all_ne = 1'b1;
        for (int f = 0; f < NF; f++) begin
            empty[f] = (cnt_q[f] == '0);
            full[f]  = (cnt_q[f] == CW'(DEPTH));
            all_ne   = all_ne & ~empty[f];
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
    // when it is also popping; an empty FIFO never bypasses.
    always_comb begin
        for (int f = 0; f < NF; f++) begin
            push[f]    = i_wr_en && (i_wr_addr == AW'(f));
            pop[f]     = i_period_start && !empty[f] && (!i_sync_mode || all_ne);
            push_ok[f] = push[f] && (!full[f] || pop[f]);
            wptr_d[f]  = push_ok[f] ? wptr_q[f] + PW'(1) : wptr_q[f];
            rptr_d[f]  = pop[f] ? rptr_q[f] + PW'(1) : rptr_q[f];
            cnt_d[f]   = cnt_q[f] + CW'(push_ok[f]) - CW'(pop[f]);
            act_d[f]   = pop[f] ? mem_q[f][rptr_q[f]] : act_q[f];
            ovf_d[f]   = (ovf_q[f] & ~i_flag_clr) | (push[f] & full[f] & ~pop[f]);
            udf_d[f]   = (udf_q[f] & ~i_flag_clr) | (i_period_start & empty[f]);
        end
        update_d = |pop;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int f = 0; f < NF; f++) begin
                wptr_q[f] <= '0;
                rptr_q[f] <= '0;
                cnt_q[f]  <= '0;
                act_q[f]  <= '0;
            end
            act_q[CHANNELS] <= '1;
            ovf_q    <= '0;
            udf_q    <= '0;
            update_q <= 1'b0;
        end else begin
            for (int f = 0; f < NF; f++) begin
                wptr_q[f] <= wptr_d[f];
                rptr_q[f] <= rptr_d[f];
                cnt_q[f]  <= cnt_d[f];
                act_q[f]  <= act_d[f];
            end
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            update_q <= update_d;
        end
    end

    // Storage needs no reset: pointers and counts define which entries are live.
    always_ff @(posedge i_clk) begin
        for (int f = 0; f < NF; f++) begin
            if (push_ok[f]) begin
                mem_q[f][wptr_q[f]] <= i_wr_data;
            end
        end
    end

    always_comb begin
        o_duty = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            o_duty[n*WIDTH +: WIDTH] = act_q[n];
        end
    end

    assign o_period    = act_q[CHANNELS];
    assign o_full      = full;
    assign o_empty     = empty;
    assign o_overflow  = ovf_q;
    assign o_underflow = udf_q;
    assign o_update    = update_q;

endmodule

// File: tb/tb_pwm_reg_fifo_mc.sv
// Bench for pwm_reg_fifo_mc: hand-derived vector table, reset-mid-fill sequence,
// then randomized traffic checked against a queue-based reference model.
module tb_pwm_reg_fifo_mc;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int C  = 2;
    localparam int NF = C + 1;
    localparam int AW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [W-1:0]    wr_data;
    logic            ps;
    logic            sync;
    logic            clr;
    logic [C*W-1:0]  duty;
    logic [W-1:0]    period;
    logic [C:0]      full, empty, ovf, udf;
    logic            upd;

    always #5 clk = ~clk;

    pwm_reg_fifo_mc #(
        .WIDTH    (W),
        .DEPTH    (D),
        .CHANNELS (C)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wr_en        (wr_en),
        .i_wr_addr      (wr_addr),
        .i_wr_data      (wr_data),
        .i_period_start (ps),
        .i_sync_mode    (sync),
        .i_flag_clr     (clr),
        .o_duty         (duty),
        .o_period       (period),
        .o_full         (full),
        .o_empty        (empty),
        .o_overflow     (ovf),
        .o_underflow    (udf),
        .o_update       (upd)
    );

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [7:0]  data;
        logic        ps;
        logic        sync;
        logic        clr;
        logic [15:0] duty;
        logic [7:0]  period;
        logic [2:0]  empty;
        logic [2:0]  full;
        logic [2:0]  ovf;
        logic [2:0]  udf;
        logic        upd;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic we, input logic [1:0] addr, input logic [7:0] data,
                       input logic p, input logic s, input logic c,
                       input logic [15:0] e_duty, input logic [7:0] e_per,
                       input logic [2:0] e_emp, input logic [2:0] e_full,
                       input logic [2:0] e_ovf, input logic [2:0] e_udf, input logic e_upd);
        vec_t v;
        v.we = we; v.addr = addr; v.data = data; v.ps = p; v.sync = s; v.clr = c;
        v.duty = e_duty; v.period = e_per; v.empty = e_emp; v.full = e_full;
        v.ovf = e_ovf; v.udf = e_udf; v.upd = e_upd;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] e_duty, input logic [7:0] e_per,
                           input logic [2:0] e_emp, input logic [2:0] e_full,
                           input logic [2:0] e_ovf, input logic [2:0] e_udf, input logic e_upd);
        chk({tag, " duty"},      32'(duty),   32'(e_duty));
        chk({tag, " period"},    32'(period), 32'(e_per));
        chk({tag, " empty"},     32'(empty),  32'(e_emp));
        chk({tag, " full"},      32'(full),   32'(e_full));
        chk({tag, " overflow"},  32'(ovf),    32'(e_ovf));
        chk({tag, " underflow"}, 32'(udf),    32'(e_udf));
        chk({tag, " update"},    32'(upd),    32'(e_upd));
    endtask

    task automatic drive(input logic we, input logic [1:0] addr, input logic [7:0] data,
                         input logic p, input logic s, input logic c);
        wr_en = we; wr_addr = addr; wr_data = data; ps = p; sync = s; clr = c;
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    logic [7:0] mq [NF][$];
    logic [7:0] ma [NF];
    logic [2:0] mo, mu;
    logic       mupd;

    initial begin
        rst = 1'b1;
        wr_en = 0; wr_addr = 0; wr_data = 0; ps = 0; sync = 0; clr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 16'h0000, 8'hFF, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0);
        rst = 1'b0;

        //   we addr data  ps sy cl   duty      per    empty   full    ovf     udf    upd
        add(0, 0, 8'h00, 0, 0, 0, 16'h0000, 8'hFF, 3'b111, 3'b000, 3'b000, 3'b000, 0);
        add(1, 0, 8'h55, 0, 0, 0, 16'h0000, 8'hFF, 3'b110, 3'b000, 3'b000, 3'b000, 0);
        add(1, 0, 8'hAB, 0, 0, 0, 16'h0000, 8'hFF, 3'b110, 3'b000, 3'b000, 3'b000, 0);
        add(1, 0, 8'hAC, 0, 0, 0, 16'h0000, 8'hFF, 3'b110, 3'b000, 3'b000, 3'b000, 0);
        add(1, 0, 8'hAD, 0, 0, 0, 16'h0000, 8'hFF, 3'b110, 3'b001, 3'b000, 3'b000, 0);
        add(1, 0, 8'hAE, 0, 0, 0, 16'h0000, 8'hFF, 3'b110, 3'b001, 3'b001, 3'b000, 0);
        add(0, 0, 8'h00, 1, 0, 0, 16'h0055, 8'hFF, 3'b110, 3'b000, 3'b001, 3'b110, 1);
        add(0, 0, 8'h00, 1, 0, 0, 16'h00AB, 8'hFF, 3'b110, 3'b000, 3'b001, 3'b110, 1);
        add(0, 0, 8'h00, 0, 0, 1, 16'h00AB, 8'hFF, 3'b110, 3'b000, 3'b000, 3'b000, 0);
        add(0, 0, 8'h00, 1, 0, 0, 16'h00AC, 8'hFF, 3'b110, 3'b000, 3'b000, 3'b110, 1);
        add(0, 0, 8'h00, 1, 0, 0, 16'h00AD, 8'hFF, 3'b111, 3'b000, 3'b000, 3'b110, 1);
        add(0, 0, 8'h00, 1, 0, 0, 16'h00AD, 8'hFF, 3'b111, 3'b000, 3'b000, 3'b111, 0);
        add(0, 0, 8'h00, 0, 0, 1, 16'h00AD, 8'hFF, 3'b111, 3'b000, 3'b000, 3'b000, 0);
        // independent mode, period only
        add(1, 2, 8'hAA, 0, 0, 0, 16'h00AD, 8'hFF, 3'b011, 3'b000, 3'b000, 3'b000, 0);
        add(0, 0, 8'h00, 1, 0, 0, 16'h00AD, 8'hAA, 3'b111, 3'b000, 3'b000, 3'b011, 1);
        add(0, 0, 8'h00, 0, 0, 1, 16'h00AD, 8'hAA, 3'b111, 3'b000, 3'b000, 3'b000, 0);
        // sync mode
        add(1, 0, 8'h10, 0, 1, 0, 16'h00AD, 8'hAA, 3'b110, 3'b000, 3'b000, 3'b000, 0);
        add(1, 2, 8'h80, 0, 1, 0, 16'h00AD, 8'hAA, 3'b010, 3'b000, 3'b000, 3'b000, 0);
        add(0, 0, 8'h00, 1, 1, 0, 16'h00AD, 8'hAA, 3'b010, 3'b000, 3'b000, 3'b010, 0);
        add(1, 1, 8'h20, 0, 1, 0, 16'h00AD, 8'hAA, 3'b000, 3'b000, 3'b000, 3'b010, 0);
        add(0, 0, 8'h00, 1, 1, 0, 16'h2010, 8'h80, 3'b111, 3'b000, 3'b000, 3'b010, 1);
        add(0, 0, 8'h00, 0, 0, 1, 16'h2010, 8'h80, 3'b111, 3'b000, 3'b000, 3'b000, 0);
        // out-of-range address
        add(1, 3, 8'h77, 0, 0, 0, 16'h2010, 8'h80, 3'b111, 3'b000, 3'b000, 3'b000, 0);
        // empty FIFO: write and period start together
        add(1, 0, 8'h33, 1, 0, 0, 16'h2010, 8'h80, 3'b110, 3'b000, 3'b000, 3'b111, 0);
        add(0, 0, 8'h00, 0, 0, 1, 16'h2010, 8'h80, 3'b110, 3'b000, 3'b000, 3'b000, 0);
        add(1, 0, 8'h01, 0, 0, 0, 16'h2010, 8'h80, 3'b110, 3'b000, 3'b000, 3'b000, 0);
        add(1, 0, 8'h02, 0, 0, 0, 16'h2010, 8'h80, 3'b110, 3'b000, 3'b000, 3'b000, 0);
        add(1, 0, 8'h03, 0, 0, 0, 16'h2010, 8'h80, 3'b110, 3'b001, 3'b000, 3'b000, 0);
        // full FIFO: write and period start together
        add(1, 0, 8'h04, 1, 0, 0, 16'h2033, 8'h80, 3'b110, 3'b001, 3'b000, 3'b110, 1);
        // overflow and clear in the same cycle: set wins
        add(1, 0, 8'h05, 0, 0, 1, 16'h2033, 8'h80, 3'b110, 3'b001, 3'b001, 3'b000, 0);
        add(0, 0, 8'h00, 0, 0, 1, 16'h2033, 8'h80, 3'b110, 3'b001, 3'b000, 3'b000, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].ps, tbl[i].sync, tbl[i].clr);
            chk_all($sformatf("vec%0d", i), tbl[i].duty, tbl[i].period, tbl[i].empty,
                    tbl[i].full, tbl[i].ovf, tbl[i].udf, tbl[i].upd);
        end

        // Reset mid-fill
        drive(1, 1, 8'h42, 0, 0, 0);
        drive(1, 2, 8'h43, 0, 0, 0);
        wr_en = 0;
        rst = 1'b1;
        #1;
        chk_all("midrst", 16'h0000, 8'hFF, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0);
        drive(1, 1, 8'h99, 1, 0, 0);
        chk_all("inrst", 16'h0000, 8'hFF, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0);
        rst = 1'b0;
        drive(0, 0, 8'h00, 1, 0, 0);
        chk_all("postrst", 16'h0000, 8'hFF, 3'b111, 3'b000, 3'b000, 3'b111, 1'b0);
        drive(0, 0, 8'h00, 0, 0, 1);
        chk_all("postclr", 16'h0000, 8'hFF, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0);

        // Randomized traffic against the queue model
        for (int f = 0; f < NF; f++) ma[f] = (f == C) ? 8'hFF : 8'h00;
        mo = '0;
        mu = '0;
        for (int k = 0; k < 500; k++) begin
            logic       r_we, r_ps, r_sy, r_cl, allne;
            logic [1:0] r_ad;
            logic [7:0] r_da;
            logic [2:0] e_emp, e_full;
            r_we = ($urandom_range(0, 3) != 0);
            r_ad = 2'($urandom_range(0, 3));
            r_da = 8'($urandom);
            r_ps = ($urandom_range(0, (k < 250) ? 7 : 2) == 0);
            r_sy = 1'($urandom_range(0, 1));
            r_cl = ($urandom_range(0, 15) == 0);

            allne = 1'b1;
            for (int f = 0; f < NF; f++) if (mq[f].size() == 0) allne = 1'b0;
            mupd = 1'b0;
            for (int f = 0; f < NF; f++) begin
                int   sz;
                logic pp, wh;
                sz = mq[f].size();
                pp = r_ps && (sz > 0) && (!r_sy || allne);
                wh = r_we && (int'(r_ad) == f);
                if (r_cl) begin
                    mo[f] = 1'b0;
                    mu[f] = 1'b0;
                end
                if (wh && sz == D && !pp) mo[f] = 1'b1;
                if (r_ps && sz == 0) mu[f] = 1'b1;
                if (pp) begin
                    ma[f] = mq[f].pop_front();
                    mupd = 1'b1;
                end
                if (wh && (sz < D || pp)) mq[f].push_back(r_da);
            end
            for (int f = 0; f < NF; f++) begin
                e_emp[f]  = (mq[f].size() == 0);
                e_full[f] = (mq[f].size() == D);
            end

            drive(r_we, r_ad, r_da, r_ps, r_sy, r_cl);
            chk_all($sformatf("rnd%0d", k), {ma[1], ma[0]}, ma[2], e_emp, e_full, mo, mu, mupd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_reg_fifo_mc.md
# pwm_reg_fifo_mc

Multi-channel, parametrised PWM register interface with depth-configurable FIFOs. It buffers duty-cycle values for `CHANNELS` PWM outputs and one shared period (switching-frequency) value, and commits them to active registers only on a period-start strobe. It also adds an all-or-nothing synchronous update mode and sticky overflow/underflow status. It sits between the host register bus and the PWM counter/comparator bank.

## Interface
- `WIDTH`, 8: bit width of duty and period values.
- `DEPTH`, 4: entries per FIFO; power of two, at least 2.
- `CHANNELS`, 2: number of duty channels, 1..15.
- `AW`, derived as `$clog2(CHANNELS+1)`: write address width.

- `i_clk`  in  1  single clock, rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_wr_en`  in  1  write strobe, one write per cycle.
- `i_wr_addr`  in  AW  target FIFO: 0..CHANNELS-1 selects a duty FIFO; CHANNELS selects the period FIFO.
- `i_wr_data`  in  WIDTH  value to push.
- `i_period_start`  in  1  single-cycle strobe from the PWM counter marking a new period.
- `i_sync_mode`  in  1  0 = per-FIFO independent update; 1 = all-or-nothing update.
- `i_flag_clr`  in  1  clears the sticky flags.
- `o_duty`  out  CHANNELS*WIDTH  active duty values; channel n occupies bits [n*WIDTH +: WIDTH].
- `o_period`  out  WIDTH  active period value.
- `o_full`  out  CHANNELS+1  per-FIFO full; bit CHANNELS is the period FIFO.
- `o_empty`  out  CHANNELS+1  per-FIFO empty.
- `o_overflow`  out  CHANNELS+1  sticky: a write arrived while that FIFO was full.
- `o_underflow`  out  CHANNELS+1  sticky: a period start occurred while that FIFO was empty.
- `o_update`  out  1  one-cycle pulse, asserted the cycle after any active register was loaded.

## Operation
- Each FIFO is a circular buffer with `log2(DEPTH)`-bit read/write pointers and a `log2(DEPTH)+1`-bit count. Pointers wrap modulo DEPTH.
- Write: when `i_wr_en` is high and the addressed FIFO is not full, `i_wr_data` is pushed. When the addressed FIFO is full, the data is dropped and the matching `o_overflow` bit is set.
- Out-of-range `i_wr_addr` (greater than CHANNELS) is ignored: no push, no flag.
- Period start with `i_sync_mode`=0: every non-empty FIFO pops its head into its active register. Each empty FIFO keeps its active value and sets its `o_underflow` bit.
- Period start with `i_sync_mode`=1: pop only if all CHANNELS+1 FIFOs are non-empty, in which case all active registers load together. Otherwise nothing pops, and every empty FIFO sets its `o_underflow` bit.
- Simultaneous push and pop on the same FIFO:
  - Both happen and count is unchanged.
  - When the FIFO is full, the push is accepted because the pop frees a slot; no overflow.
  - When the FIFO is empty, there is no bypass: the push is stored, the pop does not occur, and underflow is set.
- Flags: `i_flag_clr` clears all sticky bits. When a set event and `i_flag_clr` occur in the same cycle, the set wins.
- `o_full` and `o_empty` are combinational decodes of count.

## Timing
- Reset values: all pointers and counts 0; `o_duty` all zero; `o_period` all ones; `o_empty` all ones; `o_full`, `o_overflow`, `o_underflow` zero; `o_update` 0.
- Asserting `i_rst` mid-operation discards all buffered entries immediately. No write or pop occurs while reset is high.
- Write latency: data is in the FIFO at the rising edge where `i_wr_en` is sampled. `o_empty` deasserts after that edge.
- Commit latency: the active registers change at the edge that samples `i_period_start` high. `o_update` is high for exactly the following cycle.
- A held `i_period_start` is treated as one strobe per cycle, so the FIFO pops every cycle while it is high.
- Back-to-back writes at full rate are allowed. Throughput is one push per cycle total and one pop per FIFO per period start.

## Test plan
- Reset then idle: check `o_duty`=0, `o_period`=8'hFF, `o_empty`=3'b111, and all flags 0.
- Push duty0 values 8'h55, 8'hAB, 8'hAC, 8'hAD, then a fifth write 8'hAE. Required: `o_full[0]`=1 after the fourth write; the fifth sets `o_overflow[0]` and 8'hAE is never output. Four period starts then yield 8'h55, 8'hAB, 8'hAC, 8'hAD on `o_duty[7:0]`, each with an `o_update` pulse.
- Independent mode: push only period 8'hAA, then period start. Required: `o_period`=8'hAA, duty outputs unchanged, and `o_underflow`=3'b011.
- Sync mode: push duty0=8'h10 and period=8'h80 with duty1 empty, then period start. Required: no output change, no `o_update`, `o_underflow[1]`=1. Then push duty1=8'h20 and period start. Required: all three outputs load together and `o_update` pulses once.
- Full FIFO with simultaneous write and period start: required count stays 4 and no overflow. Empty FIFO with simultaneous write and period start: required count becomes 1, underflow set, output unchanged.
- Assert `i_flag_clr` in the same cycle as an overflow event: required flag stays 1. Clear alone: required flag becomes 0. Reset mid-fill: required `o_empty` all ones after reset.
